dense_neuron_unit: RTL and testbench

- Downstream consumer of the decode-to-dense register stage inside data_path.
- Runs one fixed-point neuron: multiply-accumulates weight × input, applies the activation, and optionally computes the output error.
- In the update phase it streams dc/dw terms with layer/row indices to the weight-storage update interface.

---
 rtl/dense_pkg.sv | 46 ++++
 rtl/dense_neuron_unit_if.sv | 41 ++++
 rtl/fx_mul.sv | 34 +++
 rtl/dense_neuron_unit.sv | 188 ++++++++++++++++++
 tb/tb_dense_neuron_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dense_pkg.sv
// dense_pkg: shared widths, op/activation encodings, FSM state codes and the
// fixed-point accumulate helper for dense_neuron_unit.
// Optional build macro: DENSE_SAT_EN (saturating accumulate instead of wrap).
package dense_pkg;

  localparam int DATA_W      = 48;
  localparam int FRAC_W      = 24;
  localparam int LEAKY_SHIFT = 3;

  localparam logic [DATA_W-1:0] FX_ONE = 48'h000001000000;
  localparam logic [DATA_W-1:0] FX_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] FX_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // dense_type op codes; unlisted codes behave as NOP
  localparam logic [3:0] DT_NOP    = 4'd0;
  localparam logic [3:0] DT_MAC    = 4'd1;
  localparam logic [3:0] DT_FINISH = 4'd2;
  localparam logic [3:0] DT_UPDATE = 4'd3;
  localparam logic [3:0] DT_CLEAR  = 4'd4;

  // activation codes; unlisted codes behave as linear
  localparam logic [3:0] ACT_LINEAR = 4'd0;
  localparam logic [3:0] ACT_RELU   = 4'd1;
  localparam logic [3:0] ACT_LEAKY  = 4'd2;

  localparam logic [7:0] COST_MSE = 8'd0;

  // controller state encoding
  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_ACT   = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  // accumulator add: wraps by default, clamps on signed overflow when enabled
  function automatic logic [DATA_W-1:0] fx_add(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    s = a + b;
`ifdef DENSE_SAT_EN
    if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]))
      s = a[DATA_W-1] ? FX_MIN : FX_MAX;
`endif
    return s;
  endfunction

endpackage

// File: rtl/dense_neuron_unit_if.sv
// dense_neuron_unit_if: register-stage fields in, activation/error/update out.
// master = controller side, slave = dense_neuron_unit.
interface dense_neuron_unit_if;
  import dense_pkg::*;

  logic              in_valid;
  logic [3:0]        dense_type;
  logic [DATA_W-1:0] w_in;
  logic [DATA_W-1:0] x_in;
  logic              load_w;
  logic [3:0]        act_type;
  logic [7:0]        cost_type;
  logic              backprop_cost;
  logic [DATA_W-1:0] label_in;
  logic              is_update;
  logic [31:0]       w_layer_index;
  logic [31:0]       w_row_index;

  logic              busy;
  logic [DATA_W-1:0] a_out;
  logic              a_valid;
  logic [DATA_W-1:0] err_out;
  logic              upd_valid;
  logic [DATA_W-1:0] dc_dw;
  logic [31:0]       upd_layer_index;
  logic [31:0]       upd_row_index;

  modport master (
    output in_valid, dense_type, w_in, x_in, load_w, act_type, cost_type,
           backprop_cost, label_in, is_update, w_layer_index, w_row_index,
    input  busy, a_out, a_valid, err_out, upd_valid, dc_dw,
           upd_layer_index, upd_row_index
  );

  modport slave (
    input  in_valid, dense_type, w_in, x_in, load_w, act_type, cost_type,
           backprop_cost, label_in, is_update, w_layer_index, w_row_index,
    output busy, a_out, a_valid, err_out, upd_valid, dc_dw,
           upd_layer_index, upd_row_index
  );
endinterface

// File: rtl/fx_mul.sv
// fx_mul: signed fixed-point multiply, full-width product rescaled by FRAC_W.
// Optional build macro: DENSE_SAT_EN (clamp instead of truncating on overflow).
module fx_mul #(
  parameter int DATA_W = 48,
  parameter int FRAC_W = 24
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic signed [2*DATA_W-1:0] prod;
  assign prod = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});

`ifdef DENSE_SAT_EN
  // everything above the kept window must replicate its sign bit to fit
  logic [DATA_W-FRAC_W:0] top;
  logic                   unused_lo;
  assign top       = prod[2*DATA_W-1 : FRAC_W+DATA_W-1];
  assign unused_lo = ^prod[FRAC_W-1:0];

  // pick the rescaled word or the clamp value on overflow
  always_comb begin
    y = prod[FRAC_W +: DATA_W];
    if (!((&top) || (~|top)))
      y = prod[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  logic unused_bits;
  assign unused_bits = ^{prod[2*DATA_W-1 : FRAC_W+DATA_W], prod[FRAC_W-1:0]};
  assign y           = prod[FRAC_W +: DATA_W];
`endif

endmodule

// File: rtl/dense_neuron_unit.sv
// dense_neuron_unit: one fixed-point neuron. Two-stage MAC into acc, FINISH
// drains the MAC pipe, applies the activation and optionally the output error;
// UPDATE streams err*x with layer/row indices to weight storage.
// Optional build macro: DENSE_SAT_EN (saturating multiply and accumulate).
module dense_neuron_unit
  import dense_pkg::*;
(
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  dense_neuron_unit_if.slave   bus
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] w_reg_q, w_reg_d;
  logic [DATA_W-1:0] err_q, err_d;
  logic [DATA_W-1:0] p_q, p_d;
  logic [1:0]        vld_pipe_q, vld_pipe_d;   // [0] product held, [1] add just retired
  logic [3:0]        act_q, act_d;
  logic              bp_q, bp_d;
  logic [7:0]        cost_q, cost_d;
  logic [DATA_W-1:0] label_q, label_d;
  logic [DATA_W-1:0] a_out_q, a_out_d;
  logic              a_valid_q, a_valid_d;
  logic              upd_valid_q, upd_valid_d;
  logic [DATA_W-1:0] dc_dw_q, dc_dw_d;
  logic [31:0]       upd_layer_q, upd_layer_d;
  logic [31:0]       upd_row_q, upd_row_d;

  logic              accept, op_mac, op_fin, op_upd, op_clr, ld_w;
  logic [DATA_W-1:0] w_eff, mac_p, upd_p;
  logic [DATA_W-1:0] a_calc, diff, err_calc;
  logic              z_neg, z_pos, unused_cost;

  assign accept = bus.in_valid && (state_q == ST_ACC);
  assign op_mac = accept && (bus.dense_type == DT_MAC);
  assign op_fin = accept && (bus.dense_type == DT_FINISH);
  assign op_upd = accept && (bus.dense_type == DT_UPDATE);
  assign op_clr = accept && (bus.dense_type == DT_CLEAR);
  assign ld_w   = bus.in_valid && bus.load_w;

  // a weight loaded alongside a MAC is used by that MAC
  assign w_eff = ld_w ? bus.w_in : w_reg_q;

  fx_mul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mac_mul (.a(w_eff), .b(bus.x_in), .y(mac_p));
  fx_mul #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_upd_mul (.a(err_q), .b(bus.x_in), .y(upd_p));

  // every cost code is currently MSE, so the latched code does not steer the math
  assign unused_cost = ^cost_q;

  assign z_neg = acc_q[DATA_W-1];
  assign z_pos = !z_neg && (acc_q != '0);

  // activation of z = acc and error delta = (a - label) * act'(z)
  always_comb begin
    diff = a_out_q - label_q;
    case (act_q)
      ACT_RELU: begin
        a_calc   = z_neg ? '0 : acc_q;
        err_calc = z_pos ? diff : '0;
      end
      ACT_LEAKY: begin
        a_calc   = z_neg ? DATA_W'($signed(acc_q) >>> LEAKY_SHIFT) : acc_q;
        err_calc = z_neg ? DATA_W'($signed(diff) >>> LEAKY_SHIFT) : diff;
      end
      default: begin
        a_calc   = acc_q;
        err_calc = diff;
      end
    endcase
  end

  // datapath next-state and controller FSM
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    err_d       = err_q;
    act_d       = act_q;
    bp_d        = bp_q;
    cost_d      = cost_q;
    label_d     = label_q;
    a_out_d     = a_out_q;
    a_valid_d   = 1'b0;
    upd_valid_d = 1'b0;
    dc_dw_d     = dc_dw_q;
    upd_layer_d = upd_layer_q;
    upd_row_d   = upd_row_q;

    w_reg_d    = ld_w ? bus.w_in : w_reg_q;
    p_d        = op_mac ? mac_p : p_q;
    vld_pipe_d = {vld_pipe_q[0], op_mac};
    if (vld_pipe_q[0]) acc_d = fx_add(acc_q, p_q);

    // CLEAR wins over a product still in flight
    if (op_clr) begin
      acc_d      = '0;
      err_d      = '0;
      vld_pipe_d = '0;
    end

    if (op_upd) begin
      dc_dw_d     = upd_p;
      upd_valid_d = bus.is_update;
      upd_layer_d = bus.w_layer_index;
      upd_row_d   = bus.w_row_index;
    end

    case (state_q)
      ST_ACC: begin
        if (op_fin) begin
          state_d = ST_DRAIN;
          act_d   = bus.act_type;
          bp_d    = bus.backprop_cost;
          cost_d  = bus.cost_type;
          label_d = bus.label_in;
        end
      end
      ST_DRAIN: begin
        if (vld_pipe_q == '0) state_d = ST_ACT;
      end
      ST_ACT: begin
        a_out_d   = a_calc;
        a_valid_d = 1'b1;
        if (bp_q) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_ACC;
          acc_d   = '0;
        end
      end
      ST_ERR: begin
        err_d   = err_calc;
        state_d = ST_ACC;
        acc_d   = '0;
      end
      default: state_d = ST_ACC;
    endcase
  end

  // state registers, all cleared by async reset
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      w_reg_q     <= '0;
      err_q       <= '0;
      p_q         <= '0;
      vld_pipe_q  <= '0;
      act_q       <= ACT_LINEAR;
      bp_q        <= 1'b0;
      cost_q      <= COST_MSE;
      label_q     <= '0;
      a_out_q     <= '0;
      a_valid_q   <= 1'b0;
      upd_valid_q <= 1'b0;
      dc_dw_q     <= '0;
      upd_layer_q <= '0;
      upd_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      w_reg_q     <= w_reg_d;
      err_q       <= err_d;
      p_q         <= p_d;
      vld_pipe_q  <= vld_pipe_d;
      act_q       <= act_d;
      bp_q        <= bp_d;
      cost_q      <= cost_d;
      label_q     <= label_d;
      a_out_q     <= a_out_d;
      a_valid_q   <= a_valid_d;
      upd_valid_q <= upd_valid_d;
      dc_dw_q     <= dc_dw_d;
      upd_layer_q <= upd_layer_d;
      upd_row_q   <= upd_row_d;
    end
  end

  assign bus.busy            = (state_q != ST_ACC);
  assign bus.a_out           = a_out_q;
  assign bus.a_valid         = a_valid_q;
  assign bus.err_out         = err_q;
  assign bus.upd_valid       = upd_valid_q;
  assign bus.dc_dw           = dc_dw_q;
  assign bus.upd_layer_index = upd_layer_q;
  assign bus.upd_row_index   = upd_row_q;

endmodule

// File: tb/tb_dense_neuron_unit.sv
// tb_dense_neuron_unit: directed bench for dense_neuron_unit with
// hand-computed Q24.24 expectations. Honours DENSE_SAT_EN for the overflow case.
module tb_dense_neuron_unit;
  import dense_pkg::*;

  localparam logic [47:0] F_ONE   = 48'h000001000000;
  localparam logic [47:0] F_TWO   = 48'h000002000000;
  localparam logic [47:0] F_THREE = 48'h000003000000;
  localparam logic [47:0] F_FOUR  = 48'h000004000000;
  localparam logic [47:0] F_FIVE  = 48'h000005000000;
  localparam logic [47:0] F_NINE  = 48'h000009000000;
  localparam logic [47:0] F_1P5   = 48'h000001800000;
  localparam logic [47:0] F_HALF  = 48'h000000800000;
  localparam logic [47:0] F_QTR   = 48'h000000400000;
  localparam logic [47:0] F_NEG4  = 48'hFFFFFC000000;
  localparam logic [47:0] F_NHALF = 48'hFFFFFF800000;
  localparam logic [47:0] F_N3_16 = 48'hFFFFFFD00000;
  localparam logic [47:0] F_MAXP  = 48'h7FFFFFFFFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dense_neuron_unit_if bus ();

  dense_neuron_unit dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.dense_type    = DT_NOP;
    bus.load_w        = 1'b0;
    bus.act_type      = ACT_LINEAR;
    bus.backprop_cost = 1'b0;
    bus.label_in      = '0;
    bus.is_update     = 1'b0;
  endtask

  // present one op for one cycle, return #1 after the edge
  task automatic issue(input logic [3:0] t, input logic [47:0] x);
    bus.in_valid   = 1'b1;
    bus.dense_type = t;
    bus.x_in       = x;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic finish(input logic [3:0] act, input logic bp, input logic [47:0] lbl);
    bus.act_type      = act;
    bus.backprop_cost = bp;
    bus.label_in      = lbl;
    issue(DT_FINISH, '0);
  endtask

  // wait (bounded) for the a_valid pulse
  task automatic wait_a(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = bus.a_valid;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  // wait (bounded) until the unit accepts ops again
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 10 && bus.busy; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic any_av;
    idle_inputs();
    bus.w_in          = '0;
    bus.x_in          = '0;
    bus.cost_type     = COST_MSE;
    bus.w_layer_index = '0;
    bus.w_row_index   = '0;

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_a_out", 64'(bus.a_out), 64'd0);
    chk("rst_a_valid", 64'(bus.a_valid), 64'd0);
    chk("rst_err", 64'(bus.err_out), 64'd0);
    chk("rst_upd_valid", 64'(bus.upd_valid), 64'd0);
    chk("rst_dc_dw", 64'(bus.dc_dw), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_a_valid", 64'(bus.a_valid), 64'd0);
    chk("rel_upd_valid", 64'(bus.upd_valid), 64'd0);

    // w=2.0, MAC 3.0 and 1.5 back-to-back, linear FINISH -> 9.0
    bus.load_w = 1'b1; bus.w_in = F_TWO;
    issue(DT_NOP, '0);
    issue(DT_MAC, F_THREE);
    issue(DT_MAC, F_1P5);
    finish(ACT_LINEAR, 1'b0, '0);
    chk("fin_busy", 64'(bus.busy), 64'd1);
    // MAC while busy must be dropped, the weight load must still land
    bus.load_w = 1'b1; bus.w_in = F_ONE;
    issue(DT_MAC, F_FIVE);
    wait_a("lin_a_valid");
    chk("lin_a_out", 64'(bus.a_out), 64'(F_NINE));
    chk("lin_idle", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    chk("lin_pulse_once", 64'(bus.a_valid), 64'd0);

    // w=1.0 now; ReLU of -4.0 -> 0
    issue(DT_MAC, F_NEG4);
    finish(ACT_RELU, 1'b0, '0);
    wait_a("relu_a_valid");
    chk("relu_a_out", 64'(bus.a_out), 64'd0);

    // leaky of -4.0 -> -0.5
    issue(DT_MAC, F_NEG4);
    finish(ACT_LEAKY, 1'b0, '0);
    wait_a("leaky_a_valid");
    chk("leaky_a_out", 64'(bus.a_out), 64'(F_NHALF));

    // leaky backprop, label 1.0: (-0.5-1.0)/8 = -0.1875
    issue(DT_MAC, F_NEG4);
    finish(ACT_LEAKY, 1'b1, F_ONE);
    wait_a("bp_a_valid");
    chk("bp_a_out", 64'(bus.a_out), 64'(F_NHALF));
    wait_idle("bp_idle");
    chk("bp_err", 64'(bus.err_out), 64'(F_N3_16));

    // linear backprop 1.5 vs label 1.0 -> err 0.5
    issue(DT_MAC, F_1P5);
    finish(ACT_LINEAR, 1'b1, F_ONE);
    wait_a("err5_a_valid");
    chk("err5_a_out", 64'(bus.a_out), 64'(F_1P5));
    wait_idle("err5_idle");
    chk("err5_err", 64'(bus.err_out), 64'(F_HALF));

    // UPDATE x=4.0 -> dc_dw 2.0 with indices 2/7
    bus.is_update = 1'b1; bus.w_layer_index = 32'd2; bus.w_row_index = 32'd7;
    issue(DT_UPDATE, F_FOUR);
    chk("upd_valid", 64'(bus.upd_valid), 64'd1);
    chk("upd_dc_dw", 64'(bus.dc_dw), 64'(F_TWO));
    chk("upd_layer", 64'(bus.upd_layer_index), 64'd2);
    chk("upd_row", 64'(bus.upd_row_index), 64'd7);
    @(posedge clk); #1;
    chk("upd_valid_drop", 64'(bus.upd_valid), 64'd0);
    // same op with is_update=0: data moves, strobe stays low
    bus.is_update = 1'b0; bus.w_layer_index = 32'd3; bus.w_row_index = 32'd9;
    issue(DT_UPDATE, F_TWO);
    chk("noupd_valid", 64'(bus.upd_valid), 64'd0);
    chk("noupd_dc_dw", 64'(bus.dc_dw), 64'(F_ONE));
    chk("noupd_layer", 64'(bus.upd_layer_index), 64'd3);

    // CLEAR right behind a MAC discards it and zeroes err
    issue(DT_MAC, F_TWO);
    issue(DT_CLEAR, '0);
    chk("clr_err", 64'(bus.err_out), 64'd0);
    finish(ACT_LINEAR, 1'b0, '0);
    wait_a("clr_a_valid");
    chk("clr_a_out", 64'(bus.a_out), 64'd0);

    // non-zero a_out, then reset while draining
    issue(DT_MAC, F_THREE);
    finish(ACT_LINEAR, 1'b0, '0);
    wait_a("pre_rst_a_valid");
    chk("pre_rst_a_out", 64'(bus.a_out), 64'(F_THREE));
    issue(DT_MAC, F_THREE);
    finish(ACT_LINEAR, 1'b0, '0);
    chk("drain_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 64'(bus.busy), 64'd0);
    chk("async_a_out", 64'(bus.a_out), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    any_av = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      any_av = any_av | bus.a_valid;
    end
    chk("post_rst_no_a_valid", 64'(any_av), 64'd0);
    // w_reg is zero after reset so this MAC adds nothing; acc must start at 0
    issue(DT_MAC, F_TWO);
    bus.load_w = 1'b1; bus.w_in = F_ONE;
    issue(DT_NOP, '0);
    issue(DT_MAC, F_QTR);
    finish(ACT_LINEAR, 1'b0, '0);
    wait_a("post_rst_a_valid");
    chk("post_rst_a_out", 64'(bus.a_out), 64'(F_QTR));

    // max positive x 2.0, weight loaded in the MAC cycle itself
    bus.load_w = 1'b1; bus.w_in = F_TWO;
    issue(DT_MAC, F_MAXP);
    finish(ACT_LINEAR, 1'b0, '0);
    wait_a("ovf_a_valid");
`ifdef DENSE_SAT_EN
    chk("ovf_a_out", 64'(bus.a_out), 64'h00007FFFFFFFFFFF);
`else
    chk("ovf_a_out", 64'(bus.a_out), 64'h0000FFFFFFFFFFFE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
